// File: rtl/sm_div_seq.sv
// Sequential sign-magnitude divider: restoring division, one quotient bit per clock.
// Results and flags are registered on the edge into DONE and held until the next completion.
module sm_div_seq #(
  parameter int DW = 4,
  parameter int VW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [DW:0]   dividend_i,
  input  logic [VW:0]   divisor_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW:0]   quotient_o,
  output logic [VW:0]   remainder_o,
  output logic          zeroFlag_o,
  output logic          negativeFlag_o,
  output logic          divZeroFlag_o
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          qsign_q, qsign_d;
  logic          rsign_q, rsign_d;

  logic [DW:0]   quot_q, quot_d;
  logic [VW:0]   remo_q, remo_d;
  logic          zero_q, zero_d;
  logic          neg_q, neg_d;
  logic          dz_q, dz_d;

  logic [VW:0]   shifted;
  logic [VW+1:0] trial;
  logic          qbit;
  logic [VW-1:0] rem_iter;
  logic [DW-1:0] quo_iter;
  logic          last_iter;
  logic          dvs_zero;

  // The partial remainder is always below the divisor, so VW bits hold it between
  // iterations; the extra bit of the trial difference is the borrow.
  always_comb begin
    shifted   = {rem_q, dvd_q[DW-1]};
    trial     = {1'b0, shifted} - {2'b00, dvs_q};
    qbit      = ~trial[VW+1];
    rem_iter  = qbit ? trial[VW-1:0] : shifted[VW-1:0];
    quo_iter  = {quo_q[DW-2:0], qbit};
    last_iter = (cnt_q == CW'(DW - 1));
    dvs_zero  = (divisor_i[VW-1:0] == '0);
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_i) begin
          dvd_d   = dividend_i[DW-1:0];
          dvs_d   = divisor_i[VW-1:0];
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          qsign_d = dividend_i[DW] ^ divisor_i[VW];
          rsign_d = dividend_i[DW];
          if (dvs_zero) begin
            // Divide-by-zero completes immediately with a fixed result.
            state_d = S_DONE;
            quot_d  = '0;
            remo_d  = '0;
            zero_d  = 1'b1;
            neg_d   = 1'b0;
            dz_d    = 1'b1;
          end else begin
            state_d = S_DIVIDE;
          end
        end
      end
      S_DIVIDE: begin
        dvd_d = {dvd_q[DW-2:0], 1'b0};
        rem_d = rem_iter;
        quo_d = quo_iter;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          // Signs are dropped on zero magnitudes so negative zero never leaves the block.
          state_d = S_DONE;
          quot_d  = {qsign_q & (|quo_iter), quo_iter};
          remo_d  = {rsign_q & (|rem_iter), rem_iter};
          zero_d  = ~(|quo_iter);
          neg_d   = qsign_q & (|quo_iter);
          dz_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
    end
  end

  assign busy_o         = (state_q == S_DIVIDE);
  assign done_o         = (state_q == S_DONE);
  assign quotient_o     = quot_q;
  assign remainder_o    = remo_q;
  assign zeroFlag_o     = zero_q;
  assign negativeFlag_o = neg_q;
  assign divZeroFlag_o  = dz_q;

endmodule

// File: tb/tb_sm_div_seq.sv
// Bench for sm_div_seq: cycle-level arithmetic model checked every cycle, plus directed
// vectors with hand-computed results and an exhaustive operand sweep.
module tb_sm_div_seq;
  localparam int DW = 4;
  localparam int VW = 2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic [4:0] dividend_i = '0;
  logic [2:0] divisor_i = '0;
  logic       busy_o, done_o;
  logic [4:0] quotient_o;
  logic [2:0] remainder_o;
  logic       zeroFlag_o, negativeFlag_o, divZeroFlag_o;

  sm_div_seq #(.DW(DW), .VW(VW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i),
    .busy_o(busy_o), .done_o(done_o),
    .quotient_o(quotient_o), .remainder_o(remainder_o),
    .zeroFlag_o(zeroFlag_o), .negativeFlag_o(negativeFlag_o),
    .divZeroFlag_o(divZeroFlag_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Result packing: {quotient[4:0], remainder[2:0], zero, negative, divZero}
  function automatic logic [10:0] model(input logic [4:0] a, input logic [2:0] b);
    int am, bm, q, r;
    logic qs, rs;
    am = int'(a[3:0]);
    bm = int'(b[1:0]);
    if (bm == 0) return {5'b0, 3'b0, 1'b1, 1'b0, 1'b1};
    q  = am / bm;
    r  = am % bm;
    qs = (a[4] ^ b[2]) && (q != 0);
    rs = a[4] && (r != 0);
    return {qs, 4'(q), rs, 2'(r), (q == 0), qs, 1'b0};
  endfunction

  logic        m_valid = 1'b0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_cnt = 0;
  logic [10:0] m_out = '0, m_pend = '0;

  // Cycle model: an accepted non-zero division occupies DW busy cycles, then one done cycle.
  always @(posedge clk_i) begin
    logic nb, nd;
    if (rst_i) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_out = '0;
    end else begin
      nb = 1'b0; nd = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin nd = 1'b1; m_out = m_pend; end
        else nb = 1'b1;
      end else if (start_i) begin
        if (divisor_i[1:0] == 2'b00) begin nd = 1'b1; m_out = model(dividend_i, divisor_i); end
        else begin m_pend = model(dividend_i, divisor_i); m_cnt = DW; nb = 1'b1; end
      end
      m_busy = nb; m_done = nd;
    end
    m_valid = 1'b1;
  end

  always @(negedge clk_i) begin
    if (m_valid)
      chk("cycle{busy,done,q,r,z,n,dz}",
          {busy_o, done_o, quotient_o, remainder_o, zeroFlag_o, negativeFlag_o, divZeroFlag_o},
          {m_busy, m_done, m_out});
  end

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    chk("done_timeout", done_o, 1'b1);
  endtask

  task automatic go(input logic [4:0] a, input logic [2:0] b, output int lat);
    @(negedge clk_i);
    start_i = 1'b1; dividend_i = a; divisor_i = b;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(lat);
  endtask

  task automatic expect_res(input string name, input logic [4:0] q, input logic [2:0] r,
                            input logic z, input logic n, input logic dz);
    chk(name, {quotient_o, remainder_o, zeroFlag_o, negativeFlag_o, divZeroFlag_o},
        {q, r, z, n, dz});
  endtask

  initial begin
    int lat;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // Pin the model to hand-computed results.
    chk("model_9_3",   model(5'b01001, 3'b011), {5'b00011, 3'b000, 3'b000});
    chk("model_-9_2",  model(5'b11001, 3'b010), {5'b10100, 3'b101, 3'b010});
    chk("model_-1_3",  model(5'b10001, 3'b011), {5'b00000, 3'b101, 3'b100});
    chk("model_5_-0",  model(5'b00101, 3'b100), {5'b00000, 3'b000, 3'b101});

    repeat (2) @(negedge clk_i);
    expect_res("reset_state", 5'b0, 3'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_busy_done", {busy_o, done_o}, 2'b00);
    rst_i = 1'b0;

    go(5'b01001, 3'b011, lat);
    chk("lat_9_3", lat, DW);
    expect_res("9/3", 5'b00011, 3'b000, 1'b0, 1'b0, 1'b0);
    go(5'b11001, 3'b010, lat);
    expect_res("-9/2", 5'b10100, 3'b101, 1'b0, 1'b1, 1'b0);
    go(5'b00111, 3'b111, lat);
    expect_res("7/-3", 5'b10010, 3'b001, 1'b0, 1'b1, 1'b0);
    go(5'b10001, 3'b011, lat);
    expect_res("-1/3", 5'b00000, 3'b101, 1'b1, 1'b0, 1'b0);
    go(5'b00010, 3'b011, lat);
    expect_res("2/3", 5'b00000, 3'b010, 1'b1, 1'b0, 1'b0);
    go(5'b00101, 3'b100, lat);
    chk("lat_divzero", lat, 0);
    expect_res("5/-0", 5'b00000, 3'b000, 1'b1, 1'b0, 1'b1);
    go(5'b00100, 3'b010, lat);
    expect_res("4/2_after_dz", 5'b00010, 3'b000, 1'b0, 1'b0, 1'b0);

    // start during busy is ignored
    @(negedge clk_i);
    start_i = 1'b1; dividend_i = 5'b01001; divisor_i = 3'b011;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1; dividend_i = 5'b00111; divisor_i = 3'b001;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(lat);
    chk("lat_ignore", lat, DW - 2);
    expect_res("ignore_busy_start", 5'b00011, 3'b000, 1'b0, 1'b0, 1'b0);

    // back-to-back: start accepted in the done cycle
    go(5'b00110, 3'b010, lat);
    expect_res("6/2", 5'b00011, 3'b000, 1'b0, 1'b0, 1'b0);
    start_i = 1'b1; dividend_i = 5'b01000; divisor_i = 3'b011;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("b2b_busy", busy_o, 1'b1);
    wait_done(lat);
    chk("lat_b2b", lat, DW);
    expect_res("8/3_b2b", 5'b00010, 3'b010, 1'b0, 1'b0, 1'b0);

    // reset two cycles into DIVIDE
    @(negedge clk_i);
    start_i = 1'b1; dividend_i = 5'b01111; divisor_i = 3'b001;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_mid_busy_done", {busy_o, done_o}, 2'b00);
    expect_res("rst_mid_outputs", 5'b0, 3'b0, 1'b0, 1'b0, 1'b0);
    repeat (DW + 2) @(negedge clk_i);
    go(5'b01111, 3'b001, lat);
    expect_res("15/1", 5'b01111, 3'b000, 1'b0, 1'b0, 1'b0);

    // exhaustive sweep with the magnitude identity
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 8; b++) begin
        logic [4:0] av;
        logic [2:0] bv;
        av = 5'(a);
        bv = 3'(b);
        go(av, bv, lat);
        chk("sweep_lat", lat, (bv[1:0] == 2'b00) ? 0 : DW);
        if (bv[1:0] != 2'b00) begin
          chk("sweep_ident", int'(quotient_o[3:0]) * int'(bv[1:0]) + int'(remainder_o[1:0]),
              int'(av[3:0]));
          chk("sweep_rem_lt", remainder_o[1:0] < bv[1:0], 1'b1);
        end
      end
    end

    @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sm_div_seq.md
Name: sm_div_seq

Overview:
- Sequential sign-magnitude divider. It is the inverse operation of the sign-magnitude multiplier in the calculator datapath.
- Takes a 5-bit sign-magnitude dividend (the multiplier's product format) and a 3-bit sign-magnitude divisor (the multiplier's operand format).
- Returns a sign-magnitude quotient and remainder, plus zero, negative and divide-by-zero flags.
- Uses restoring division, one quotient bit per clock, with a start/busy/done handshake.

Parameters:
- DW, 4, dividend and quotient magnitude width; sign is bit DW.
- VW, 2, divisor and remainder magnitude width; sign is bit VW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- dividend  in  DW+1  sign-magnitude; bit DW is the sign.
- divisor  in  VW+1  sign-magnitude; bit VW is the sign.
- busy  out  1  high while an iteration is in progress.
- done  out  1  one-cycle pulse when the results are valid.
- quotient  out  DW+1  sign-magnitude quotient.
- remainder  out  VW+1  sign-magnitude remainder.
- zeroFlag  out  1  quotient magnitude == 0.
- negativeFlag  out  1  equals quotient[DW] after normalisation.
- divZeroFlag  out  1  last accepted operation had divisor magnitude == 0.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high and overrides every other input, including mid-operation. On rst: state=IDLE; busy, done, quotient, remainder, zeroFlag, negativeFlag and divZeroFlag are all 0. An in-flight operation is discarded with no done pulse.
- States: IDLE, DIVIDE, DONE.
- Accept:
  - In IDLE or DONE, start=1 at cycle N captures dividend and divisor.
  - Divisor magnitude != 0: go to DIVIDE. busy=1 from cycle N+1 through N+DW.
  - Divisor magnitude == 0: go to DONE directly.
  - start while busy=1 is ignored; operands are not captured.
- DIVIDE:
  - DW cycles. Each cycle shifts the partial remainder (VW+1 bits) left, brings in the next dividend magnitude bit (MSB first), and trial-subtracts the divisor magnitude.
  - If non-negative: keep the difference, quotient bit=1. Otherwise restore, quotient bit=0.
  - After the DW-th iteration go to DONE.
- DONE:
  - done=1 and busy=0 in cycle N+DW+1 (N+1 for divide-by-zero). done lasts exactly one cycle.
  - State then returns to IDLE unless start=1 in that same cycle. A start in the DONE cycle is accepted (back-to-back).
- Sign rules:
  - Quotient sign = dividend sign XOR divisor sign.
  - Remainder sign = dividend sign (truncating division).
  - |dividend| = q·|divisor| + r, with 0 <= r < |divisor|.
- Zero normalisation: any zero-magnitude result is output with sign bit 0. Negative zero is never produced on quotient or remainder.
- Flags:
  - zeroFlag = (quotient magnitude == 0).
  - negativeFlag = quotient[DW] after normalisation.
  - Both are registered together with quotient.
- Divide-by-zero: quotient=0, remainder=0, zeroFlag=1, negativeFlag=0, divZeroFlag=1.
- Holding: quotient, remainder and all flags update only on the edge into DONE. They hold their values otherwise, including while the next operation is busy.
- divZeroFlag clears on the next successful completion.
- Input width rules: negative-zero operands are legal and treated as magnitude 0. The divisor sign of a zero divisor is ignored.

Test Plan:
- rst=1 for 2 cycles, then start 01001 / 011 (9/3) -> busy for 4 cycles; done in cycle N+5; quotient=00011, remainder=000, zeroFlag=0, negativeFlag=0.
- 11001 / 010 (-9/2) -> quotient=10100, remainder=101, negativeFlag=1. Then 00111 / 111 (7/-3) -> quotient=10010, remainder=001.
- 10001 / 011 (-1/3) -> quotient=00000 (sign normalised), remainder=101, zeroFlag=1, negativeFlag=0. Also 00010 / 011 -> quotient=00000, remainder=010.
- 00101 / 100 (divide by -0) -> done at N+1, busy never high, divZeroFlag=1, quotient=00000, remainder=000. Next 00100 / 010 -> quotient=00010, divZeroFlag=0.
- start pulsed again during busy with different operands -> ignored; original result delivered. start in the done cycle -> second result after a further DW+1 cycles.
- rst asserted 2 cycles into DIVIDE -> next cycle busy=0, all outputs 0, no done pulse. A subsequent 01111 / 001 -> quotient=01111, remainder=000.
- Exhaustive sweep: all 32 × 8 operand combinations checked against the sign rules and the magnitude identity.
